// File: rtl/rtc_escritura_if.sv
// rtc_escritura_if: request, RTC bus and status signals of rtc_escritura
//   master: drives inicio/leer/dir/dato/din, observes the bus and status outputs
//   slave : the controller side (rtc_escritura)
interface rtc_escritura_if;
   logic       inicio;
   logic       leer;
   logic [7:0] dir;
   logic [7:0] dato;
   logic [7:0] din;
   logic [7:0] dout;
   logic       listo;
   logic       cs_n;
   logic       ad_n;
   logic       wr_n;
   logic       rd_n;
   logic [7:0] dato_leido;
   logic       ocupado;
   logic       fin;
   modport master(output inicio, leer, dir, dato, din,
                  input dout, listo, cs_n, ad_n, wr_n, rd_n, dato_leido, ocupado, fin);
   modport slave(input inicio, leer, dir, dato, din,
                 output dout, listo, cs_n, ad_n, wr_n, rd_n, dato_leido, ocupado, fin);
endinterface

// File: rtl/rtc_escritura.sv
// rtc_escritura: multiplexed address/data RTC bus cycle generator
//   clk, reset (sync, active-high); bus: rtc_escritura_if.slave
//   T_FASE: cycles per bus phase (1..255)
//   RTC_LECTURA_EN: when defined, leer=1 runs a read data phase capturing din
module rtc_escritura #(
   parameter int unsigned T_FASE = 4
) (
   input logic             clk,
   input logic             reset,
   rtc_escritura_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN} state_t;
   localparam logic [7:0] T8 = 8'(T_FASE);
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] dir_q, dir_d;
   logic [7:0] dato_q, dato_d;
   logic [7:0] leido_q, leido_d;
   logic       lectura;
   logic       acepta;
   logic       fase_a, fase_d;
   assign acepta = state_q == IDLE && bus.inicio;
`ifdef RTC_LECTURA_EN
   logic leer_q, leer_d;
   always_comb leer_d = acepta ? bus.leer : leer_q;
   always_ff @(posedge clk) leer_q <= reset ? 1'b0 : leer_d;
   assign lectura = leer_q;
`else
   assign lectura = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = acepta ? bus.dir : dir_q;
      dato_d  = acepta ? bus.dato : dato_q;
      // the RTC's data is sampled on the last cycle of the read strobe
      leido_d = (lectura && state_q == D_STB && cnt_q == 8'd1) ? bus.din : leido_q;
      if (state_q == IDLE) begin
         state_d = bus.inicio ? A_SET : IDLE;
         cnt_d   = bus.inicio ? T8 : 8'd0;
      end else if (state_q == FIN) begin
         state_d = IDLE;
         cnt_d   = 8'd0;
      end else if (cnt_q == 8'd1) begin
         // timed states are consecutive in the encoding, D_HLD falls through to FIN
         state_d = state_t'(state_q + 3'd1);
         cnt_d   = state_q == D_HLD ? 8'd0 : T8;
      end else begin
         cnt_d = cnt_q - 8'd1;
      end
   end
   always_ff @(posedge clk) begin
      state_q <= reset ? IDLE : state_d;
      cnt_q   <= reset ? 8'd0 : cnt_d;
      dir_q   <= reset ? 8'd0 : dir_d;
      dato_q  <= reset ? 8'd0 : dato_d;
      leido_q <= reset ? 8'd0 : leido_d;
   end
   assign fase_a         = state_q inside {A_SET, A_STB, A_HLD};
   assign fase_d         = state_q inside {D_SET, D_STB, D_HLD};
   assign bus.cs_n       = ~(fase_a | fase_d);
   assign bus.ad_n       = state_q != A_STB;
   assign bus.wr_n       = ~(state_q == A_STB || (state_q == D_STB && !lectura));
   assign bus.rd_n       = ~(state_q == D_STB && lectura);
   // the RTC owns the data lines for the whole read data phase
   assign bus.listo      = fase_a | (fase_d & ~lectura);
   assign bus.dout       = fase_a ? dir_q : fase_d ? dato_q : 8'h00;
   assign bus.dato_leido = leido_q;
   assign bus.ocupado    = state_q != IDLE;
   assign bus.fin        = state_q == FIN;
endmodule
